core_bus_arbiter: RTL
=====================

// Module: core_bus_arbiter
// PURPOSE
//   Shares one downstream memory/MMU bus port between the core's instruction-fetch port and its
//   load/store port. Buffers one single-cycle request pulse per requester, grants them round-robin,
//   keeps a single transaction outstanding, and routes the response or MMU exception back to the
//   owning requester. Sits between the core and the MMU/memory interconnect.
// PARAMETERS
//   ADDR_W   32  address width
//   DATA_W   32  data width; strobe width is DATA_W/8
// PORTS
//   clk             in   1         clock, all state on rising edge
//   rst             in   1         reset, asynchronous, active-high
//   f_req_en        in   1         fetch request pulse (1 cycle)
//   f_mode          in   1         fetch mode (0 read, 1 write)
//   f_addr/f_wdata  in   ADDR_W/DATA_W  fetch address / write data
//   f_wstrb         in   DATA_W/8  fetch byte strobes
//   f_resp_en       out  1         fetch response pulse
//   f_resp_data     out  DATA_W    fetch response data
//   f_exc_en        out  1         fetch exception pulse
//   m_req_en, m_mode, m_addr, m_wdata, m_wstrb    in   as f_*   load/store request
//   m_resp_en, m_resp_data, m_exc_en              out  as f_*   load/store response / exception
//   exc_vec/exc_tval  out 5/32     exception cause / tval, valid with f_exc_en or m_exc_en
//   b_req_en        out  1         downstream request pulse
//   b_mode, b_addr, b_wdata, b_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  downstream request fields
//   b_resp_en       in   1         downstream response pulse
//   b_resp_data     in   DATA_W    downstream response data
//   b_exc_en        in   1         downstream exception pulse; terminates the transaction
//   b_exc_vec/b_exc_tval  in 5/32  downstream exception cause / tval
//   proto_err       out  1         sticky protocol-violation flag
// BEHAVIOUR
//   - Reset: all outputs 0; both pending buffers empty; state IDLE; last_grant = MEM (fetch wins first tie).
//   - Pending buffers: one entry per port. X_req_en captures mode/addr/wdata/wstrb and sets pend_X.
//     Request while pend_X set or X owns the bus: dropped, proto_err<=1 (sticky until rst).
//   - FSM IDLE -> ISSUE -> WAIT -> IDLE.
//     IDLE: if any pend_X, pick owner (only one pending: that one; both: the one != last_grant),
//       clear pend_owner, set last_grant=owner, go ISSUE. Request arriving this cycle is only
//       buffered, not granted, so an idle request pulse at cycle N gives b_req_en at cycle N+2.
//     ISSUE: b_req_en=1 for exactly this cycle, b_* fields driven from owner's buffer. Go WAIT.
//     WAIT: b_* fields held stable; on b_resp_en (cycle M) register owner's resp pulse + data
//       for cycle M+1; on b_exc_en register owner's exc pulse + exc_vec/exc_tval for cycle M+1.
//       Both in the same cycle: exception wins, response dropped. Go IDLE.
//   - Response/exception pulses are exactly one cycle; resp_data/exc fields hold until next pulse.
//   - Back-to-back: earliest next b_req_en is cycle M+2 after response at M (no bubble beyond).
//   - A requester's new pulse at the same cycle as its own response completion is accepted
//     (ownership ends that cycle).
//   - b_resp_en/b_exc_en outside WAIT: ignored, proto_err<=1.
//   - Async reset mid-transaction: transaction abandoned, no response forwarded; any late
//     downstream response then falls under the previous rule.
//   - Never more than one downstream transaction outstanding.
// TESTING
//   1. Reset, f_req_en addr 0x1000 at cycle 2 -> b_req_en cycle 4 addr 0x1000; b_resp_en data
//      0xDEADBEEF cycle 7 -> f_resp_en cycle 8 data 0xDEADBEEF, m_resp_en stays 0.
//   2. f_req_en and m_req_en same cycle after reset -> fetch granted first, then mem; next
//      simultaneous pair -> fetch first again (after a mem grant); alternation over 8 pairs.
//   3. m_req_en write 0x2000/0xA5A5A5A5/strobe 0x3 during fetch WAIT -> issued at M+2 with
//      identical fields, fields stable until response.
//   4. b_exc_en vec 13 tval 0x3000 with b_resp_en same cycle for mem txn -> m_exc_en=1,
//      exc_vec=13, exc_tval=0x3000, m_resp_en=0.
//   5. Second f_req_en while fetch pending; b_resp_en in IDLE -> proto_err=1, dropped request
//      never issued.
//   6. Assert rst during WAIT -> all outputs 0 async; post-reset b_resp_en not forwarded.

Source files
------------

// File: rtl/core_bus_arbiter_if.sv
// Bundle of the fetch, load/store and downstream bus signals around core_bus_arbiter.
// The arbiter is the slave side; the core plus the MMU/memory model form the master side.
interface core_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  f_req_en;
  logic                  f_mode;
  logic [ADDR_W-1:0]     f_addr;
  logic [DATA_W-1:0]     f_wdata;
  logic [DATA_W/8-1:0]   f_wstrb;
  logic                  f_resp_en;
  logic [DATA_W-1:0]     f_resp_data;
  logic                  f_exc_en;

  logic                  m_req_en;
  logic                  m_mode;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W/8-1:0]   m_wstrb;
  logic                  m_resp_en;
  logic [DATA_W-1:0]     m_resp_data;
  logic                  m_exc_en;

  logic [4:0]            exc_vec;
  logic [31:0]           exc_tval;

  logic                  b_req_en;
  logic                  b_mode;
  logic [ADDR_W-1:0]     b_addr;
  logic [DATA_W-1:0]     b_wdata;
  logic [DATA_W/8-1:0]   b_wstrb;
  logic                  b_resp_en;
  logic [DATA_W-1:0]     b_resp_data;
  logic                  b_exc_en;
  logic [4:0]            b_exc_vec;
  logic [31:0]           b_exc_tval;

  logic                  proto_err;

  modport slave (
    input  f_req_en, f_mode, f_addr, f_wdata, f_wstrb,
    output f_resp_en, f_resp_data, f_exc_en,
    input  m_req_en, m_mode, m_addr, m_wdata, m_wstrb,
    output m_resp_en, m_resp_data, m_exc_en,
    output exc_vec, exc_tval,
    output b_req_en, b_mode, b_addr, b_wdata, b_wstrb,
    input  b_resp_en, b_resp_data, b_exc_en, b_exc_vec, b_exc_tval,
    output proto_err
  );

  modport master (
    output f_req_en, f_mode, f_addr, f_wdata, f_wstrb,
    input  f_resp_en, f_resp_data, f_exc_en,
    output m_req_en, m_mode, m_addr, m_wdata, m_wstrb,
    input  m_resp_en, m_resp_data, m_exc_en,
    input  exc_vec, exc_tval,
    input  b_req_en, b_mode, b_addr, b_wdata, b_wstrb,
    output b_resp_en, b_resp_data, b_exc_en, b_exc_vec, b_exc_tval,
    input  proto_err
  );
endinterface

// File: rtl/core_bus_arbiter.sv
// Round-robin arbiter sharing one downstream bus between the fetch and load/store ports.
// One buffered request per port, one outstanding transaction, responses routed to the owner.
module core_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  core_bus_arbiter_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic {OWN_F, OWN_M} owner_t;

  state_t              r_state, w_state_nxt;
  owner_t              r_owner, r_last_grant, w_grant_owner;
  logic                w_grant;

  logic                r_pend_f, r_pend_m;
  logic                r_f_mode, r_m_mode;
  logic [ADDR_W-1:0]   r_f_addr, r_m_addr;
  logic [DATA_W-1:0]   r_f_wdata, r_m_wdata;
  logic [STRB_W-1:0]   r_f_wstrb, r_m_wstrb;

  logic                r_b_mode;
  logic [ADDR_W-1:0]   r_b_addr;
  logic [DATA_W-1:0]   r_b_wdata;
  logic [STRB_W-1:0]   r_b_wstrb;

  logic                r_f_resp_en, r_m_resp_en, r_f_exc_en, r_m_exc_en;
  logic [DATA_W-1:0]   r_f_resp_data, r_m_resp_data;
  logic [4:0]          r_exc_vec;
  logic [31:0]         r_exc_tval;
  logic                r_proto_err;

  logic w_done, w_f_busy, w_m_busy, w_f_accept, w_m_accept, w_f_drop, w_m_drop, w_stray;

  // Ownership ends in the completion cycle, so the owner may re-request in that same cycle.
  assign w_done     = (r_state == S_WAIT) && (bus.b_resp_en || bus.b_exc_en);
  assign w_f_busy   = r_pend_f || ((r_state != S_IDLE) && (r_owner == OWN_F) && !w_done);
  assign w_m_busy   = r_pend_m || ((r_state != S_IDLE) && (r_owner == OWN_M) && !w_done);
  assign w_f_accept = bus.f_req_en && !w_f_busy;
  assign w_m_accept = bus.m_req_en && !w_m_busy;
  assign w_f_drop   = bus.f_req_en && w_f_busy;
  assign w_m_drop   = bus.m_req_en && w_m_busy;
  assign w_stray    = (bus.b_resp_en || bus.b_exc_en) && (r_state != S_WAIT);

  always_comb begin
    w_state_nxt   = r_state;
    w_grant       = 1'b0;
    w_grant_owner = r_owner;
    unique case (r_state)
      S_IDLE: begin
        if (r_pend_f || r_pend_m) begin
          w_grant = 1'b1;
          if (r_pend_f && r_pend_m)
            w_grant_owner = (r_last_grant == OWN_F) ? OWN_M : OWN_F;
          else
            w_grant_owner = r_pend_f ? OWN_F : OWN_M;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.b_resp_en || bus.b_exc_en) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_f  <= 1'b0;
      r_pend_m  <= 1'b0;
      r_f_mode  <= 1'b0;
      r_f_addr  <= '0;
      r_f_wdata <= '0;
      r_f_wstrb <= '0;
      r_m_mode  <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_m_wstrb <= '0;
    end else begin
      if (w_grant && (w_grant_owner == OWN_F)) r_pend_f <= 1'b0;
      if (w_grant && (w_grant_owner == OWN_M)) r_pend_m <= 1'b0;
      if (w_f_accept) begin
        r_pend_f  <= 1'b1;
        r_f_mode  <= bus.f_mode;
        r_f_addr  <= bus.f_addr;
        r_f_wdata <= bus.f_wdata;
        r_f_wstrb <= bus.f_wstrb;
      end
      if (w_m_accept) begin
        r_pend_m  <= 1'b1;
        r_m_mode  <= bus.m_mode;
        r_m_addr  <= bus.m_addr;
        r_m_wdata <= bus.m_wdata;
        r_m_wstrb <= bus.m_wstrb;
      end
    end
  end

  // Downstream fields latch at grant and stay put through ISSUE and WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= OWN_F;
      r_last_grant <= OWN_M;
      r_b_mode     <= 1'b0;
      r_b_addr     <= '0;
      r_b_wdata    <= '0;
      r_b_wstrb    <= '0;
    end else if (w_grant) begin
      r_owner      <= w_grant_owner;
      r_last_grant <= w_grant_owner;
      r_b_mode     <= (w_grant_owner == OWN_F) ? r_f_mode  : r_m_mode;
      r_b_addr     <= (w_grant_owner == OWN_F) ? r_f_addr  : r_m_addr;
      r_b_wdata    <= (w_grant_owner == OWN_F) ? r_f_wdata : r_m_wdata;
      r_b_wstrb    <= (w_grant_owner == OWN_F) ? r_f_wstrb : r_m_wstrb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f_resp_en   <= 1'b0;
      r_m_resp_en   <= 1'b0;
      r_f_exc_en    <= 1'b0;
      r_m_exc_en    <= 1'b0;
      r_f_resp_data <= '0;
      r_m_resp_data <= '0;
      r_exc_vec     <= '0;
      r_exc_tval    <= '0;
      r_proto_err   <= 1'b0;
    end else begin
      r_f_resp_en <= 1'b0;
      r_m_resp_en <= 1'b0;
      r_f_exc_en  <= 1'b0;
      r_m_exc_en  <= 1'b0;
      if (r_state == S_WAIT) begin
        if (bus.b_exc_en) begin
          if (r_owner == OWN_F) r_f_exc_en <= 1'b1;
          else                  r_m_exc_en <= 1'b1;
          r_exc_vec  <= bus.b_exc_vec;
          r_exc_tval <= bus.b_exc_tval;
        end else if (bus.b_resp_en) begin
          if (r_owner == OWN_F) begin
            r_f_resp_en   <= 1'b1;
            r_f_resp_data <= bus.b_resp_data;
          end else begin
            r_m_resp_en   <= 1'b1;
            r_m_resp_data <= bus.b_resp_data;
          end
        end
      end
      if (w_f_drop || w_m_drop || w_stray) r_proto_err <= 1'b1;
    end
  end

  assign bus.b_req_en    = (r_state == S_ISSUE);
  assign bus.b_mode      = r_b_mode;
  assign bus.b_addr      = r_b_addr;
  assign bus.b_wdata     = r_b_wdata;
  assign bus.b_wstrb     = r_b_wstrb;
  assign bus.f_resp_en   = r_f_resp_en;
  assign bus.f_resp_data = r_f_resp_data;
  assign bus.f_exc_en    = r_f_exc_en;
  assign bus.m_resp_en   = r_m_resp_en;
  assign bus.m_resp_data = r_m_resp_data;
  assign bus.m_exc_en    = r_m_exc_en;
  assign bus.exc_vec     = r_exc_vec;
  assign bus.exc_tval    = r_exc_tval;
  assign bus.proto_err   = r_proto_err;
endmodule
